// File: rtl/booth8_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : booth8_accumulator
//  Purpose  : Accumulator stage of a radix-8 Booth multiplier. Takes one
//             signed partial product per clock from the forming logic, adds it
//             in at the top of a wide accumulator, and shifts the sum right by
//             3 bits. After ITER digits it presents the signed 2k-bit product
//             and raises done.
//  Revision : 1.0  initial release
//
//  Parameters
//    k       operand width (two's complement). Must match the forming logic.
//    ITER    radix-8 digit count, (k+2)/3. Derived; not overridable.
//
//  Ports
//    clk      in   1     rising-edge clock
//    rst      in   1     synchronous reset, active-high, overrides start
//    start    in   1     one-cycle pulse shared with the forming logic
//    srcA     in   k+3   signed partial product, valid in every RUN cycle
//    product  out  2k    signed product, holds its last completed value
//    busy     out  1     high while digits are being accumulated
//    done     out  1     completion flag
//
//  Build option
//    BOOTH8_ACC_STICKY_DONE_EN
//      defined   : done rises in the DONE cycle and stays high until the
//                  next accepted start or rst.
//      undefined : done is a one-cycle pulse in the DONE cycle.
// ============================================================================
module booth8_accumulator #(
  parameter int k = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [k+2:0]   srcA,
  output logic [2*k-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int ITER  = (k + 2) / 3;
  localparam int ACC_W = 3 * ITER + k + 4;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int SA_W  = k + 3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*k-1:0]          product_q, product_d;
  logic                    done_q, done_d;

  logic signed [ACC_W-1:0] w_src_ext;
  logic signed [ACC_W-1:0] w_addend;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_acc_step;

  // Each new digit enters at weight 3*ITER; the ITER-i shifts that follow
  // bring digit i down to weight 3i. ACC_W leaves headroom so the sum is
  // never truncated before the arithmetic shift.
  assign w_src_ext  = {{(ACC_W - SA_W){srcA[SA_W-1]}}, srcA};
  assign w_addend   = w_src_ext <<< (3 * ITER);
  assign w_sum      = acc_q + w_addend;
  assign w_acc_step = w_sum >>> 3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef BOOTH8_ACC_STICKY_DONE_EN
    done_d    = done_q;
`else
    done_d    = 1'b0;
`endif

    // start restarts from any state; an operation cut short never updates
    // product and never raises done.
    if (start) begin
      state_d = S_RUN;
      acc_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_RUN: begin
          acc_d = w_acc_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            product_d = w_acc_step[2*k-1:0];
            state_d   = S_DONE;
            done_d    = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign product = product_q;
  assign busy    = (state_q == S_RUN);
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_booth8_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth8_accumulator
//  Purpose  : Self-checking bench for booth8_accumulator (k=4). Radix-8 Booth
//             digits are generated here from the multiplier, multiplied by
//             the multiplicand and driven on srcA; the expected product a*x
//             goes into a scoreboard and is checked when done rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth8_accumulator;

  localparam int K = 4;
`ifdef BOOTH8_ACC_STICKY_DONE_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [K+2:0]   srcA;
  logic [2*K-1:0] product;
  logic           busy;
  logic           done;

  int tests = 0;
  int fails = 0;

  logic [2*K-1:0] sb[$];
  logic           done_prev = 1'b0;

  booth8_accumulator #(.k(K)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .srcA    (srcA),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Radix-8 Booth digit i of multiplier x: -4*x[3i+2] + 2*x[3i+1] + x[3i] + x[3i-1]
  function automatic int bdig(input logic signed [3:0] x, input int i);
    int         xe;
    logic [8:0] t;
    xe = int'(x);
    t  = {xe[7:0], 1'b0};
    return -4 * int'(t[3*i+3]) + 2 * int'(t[3*i+2]) + int'(t[3*i+1]) + int'(t[3*i]);
  endfunction

  function automatic logic [K+2:0] pp(input logic signed [3:0] x, input logic signed [3:0] a, input int i);
    int v;
    v = bdig(x, i) * int'(a);
    return v[K+2:0];
  endfunction

  function automatic logic [2*K-1:0] ref_prod(input logic signed [3:0] x, input logic signed [3:0] a);
    int p;
    p = int'(x) * int'(a);
    return p[2*K-1:0];
  endfunction

  // Scoreboard monitor: every rising done must match the oldest expected product.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      tests++;
      assert (sb.size() > 0)
      else begin
        fails++;
        $error("FAIL done_unexpected: observed done with product %0h expected no done", product);
      end
      if (sb.size() > 0) chk("product", product, sb.pop_front());
    end
    done_prev = done;
  end

  // Full operation with timing checks. pre_done is the done level expected
  // just before the start is accepted.
  task automatic run_op(input logic signed [3:0] x, input logic signed [3:0] a, input logic pre_done);
    @(posedge clk); #1 start = 1'b1; srcA = '0;
    @(negedge clk); chk("done_before_start", done, pre_done);
    sb.push_back(ref_prod(x, a));
    @(posedge clk); #1 start = 1'b0; srcA = pp(x, a, 0);
    @(negedge clk); chk("busy_run0", busy, 1); chk("done_run0", done, 0);
    @(posedge clk); #1 srcA = pp(x, a, 1);
    @(negedge clk); chk("busy_run1", busy, 1); chk("done_run1", done, 0);
    @(posedge clk); #1 srcA = '0;
    @(negedge clk); chk("busy_done", busy, 0); chk("done_latency", done, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("done_after", done, STICKY); chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; srcA = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_product", product, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_op(4'sd3, 4'sd5, 1'b0);            // 0x0F
    run_op(-4'sd8, -4'sd8, STICKY);        // 0x40

    // done level through a long idle stretch
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("done_idle", done, STICKY);
    end

    run_op(4'sd7, -4'sd8, STICKY);         // 0xC8

    // Restart: first op aborted after one RUN cycle with srcA=+5
    @(posedge clk); #1 start = 1'b1; srcA = '0;
    @(posedge clk); #1 start = 1'b1; srcA = 7'sd5;
    @(negedge clk); chk("abort_busy", busy, 1); chk("abort_product", product, 8'hC8);
    chk("abort_done", done, 0);
    sb.push_back(ref_prod(4'sd2, 4'sd6));
    @(posedge clk); #1 start = 1'b0; srcA = pp(4'sd2, 4'sd6, 0);
    @(negedge clk); chk("restart_product0", product, 8'hC8); chk("restart_done0", done, 0);
    @(posedge clk); #1 srcA = pp(4'sd2, 4'sd6, 1);
    @(negedge clk); chk("restart_product1", product, 8'hC8); chk("restart_done1", done, 0);
    @(posedge clk); #1 srcA = '0;
    @(negedge clk); chk("restart_done", done, 1); chk("restart_result", product, 8'h0C);

    run_op(4'sd0, -4'sd3, STICKY);         // 0x00, done still produced
    run_op(4'sd3, 4'sd5, STICKY);          // 0x0F

    // rst during RUN, with start in the same cycle
    @(posedge clk); #1 start = 1'b1; srcA = '0;
    @(posedge clk); #1 start = 1'b1; rst = 1'b1; srcA = pp(4'sd3, 4'sd5, 0);
    @(negedge clk); chk("prerst_busy", busy, 1);
    @(posedge clk); #1 start = 1'b0; rst = 1'b0; srcA = '0;
    @(negedge clk);
    chk("rstrun_product", product, 0); chk("rstrun_busy", busy, 0); chk("rstrun_done", done, 0);
    repeat (3) begin
      @(negedge clk); chk("rstrun_stays_idle", busy, 0);
    end

    run_op(-4'sd5, 4'sd7, 1'b0);           // -35 = 0xDD

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
